// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: RV32M op encodings, MDU FSM states and the
// funct7 value the decoder uses to route R-type ops to the MDU.
package mycpu_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_FIX,
    MDU_DONE
  } mdu_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic md_is_div(md_op_e op);
    logic [2:0] v;
    v = op;
    return v[2];
  endfunction

  function automatic logic md_is_rem(md_op_e op);
    logic [2:0] v;
    v = op;
    return v[2] & v[1];
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with sign fix-up and optional early-out for div corner cases.
module mdu_iter
  import mycpu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  md_op_e              op_q, op_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [XLEN-1:0]     result_q, result_d;

  md_op_e              op_in;
  logic                accept;
  logic                sign_a, sign_b;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic                div_zero, div_ovf;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  // Operand decode for the request presented this cycle
  always_comb begin
    op_in    = md_op_e'(funct3_i);
    accept   = req_valid_i & (state_q == MDU_IDLE);
    sign_a   = rs1_i[XLEN-1] & (op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sign_b   = rs2_i[XLEN-1] & (op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
    abs_a    = sign_a ? -rs1_i : rs1_i;
    abs_b    = sign_b ? -rs2_i : rs2_i;
    div_zero = (rs2_i == '0);
    div_ovf  = (op_in inside {MD_DIV, MD_REM}) && (rs1_i == MIN_INT) && (rs2_i == '1);
  end

  // One iteration step for each datapath; acc holds {hi/remainder, lo/multiplier-or-dividend}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (!div_diff[XLEN]) begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;

    unique case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          cnt_d   = CW'(XLEN);
          state_d = MDU_CALC;
          if (md_is_div(op_in)) begin
            acc_d = {{XLEN{1'b0}}, abs_a};
            opb_d = abs_b;
            // Quotient of x/0 must stay all-ones, so its sign fix is suppressed
            neg_d = md_is_rem(op_in) ? sign_a : ((sign_a ^ sign_b) & ~div_zero);
            if (EARLY_OUT && (div_zero || div_ovf)) begin
              state_d = MDU_DONE;
              if (div_zero) result_d = md_is_rem(op_in) ? rs1_i : '1;
              else          result_d = md_is_rem(op_in) ? '0 : MIN_INT;
            end
          end else begin
            acc_d = {{XLEN{1'b0}}, abs_b};
            opb_d = abs_a;
            neg_d = sign_a ^ sign_b;
          end
        end
      end
      MDU_CALC: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = md_is_div(op_q) ? div_next : mul_next;
        if (cnt_q == CW'(1)) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        unique case (op_q)
          MD_MUL:                       result_d = prod_fix[XLEN-1:0];
          MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
          MD_DIV, MD_DIVU:              result_d = quo_fix;
          default:                      result_d = rem_fix;
        endcase
        state_d = MDU_DONE;
      end
      MDU_DONE: begin
        if (res_ready_i) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase

    if (flush_i) state_d = MDU_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign req_ready_o = (state_q == MDU_IDLE);
  assign res_valid_o = (state_q == MDU_DONE);
  assign busy_o      = (state_q != MDU_IDLE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench: two MDUs (EARLY_OUT=0 and 1) share stimulus; a monitor
// checks each result, its latency and its stability against a plain-arithmetic model.
module tb_mdu_iter;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        res_ready = 1'b0;
  logic        req_ready [2];
  logic        res_valid [2];
  logic        busy [2];
  logic [31:0] result [2];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int rr_mode = 0;  // 0 random, 1 hold low, 2 hold high

  typedef struct {
    logic [31:0] val;
    int          acc;
    bit          early;
  } exp_t;

  exp_t        q[$];
  int          head [2];
  bit          seen [2];
  logic [31:0] first [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mdu_iter #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(req_ready[0]), .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2),
    .res_valid_o(res_valid[0]), .res_ready_i(res_ready), .result_o(result[0]),
    .busy_o(busy[0]));

  mdu_iter #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(req_ready[1]), .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2),
    .res_valid_o(res_valid[1]), .res_ready_i(res_ready), .result_o(result[1]),
    .busy_o(busy[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_md(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      0: begin p = 64'(sa * sb); return p[31:0];  end
      1: begin p = 64'(sa * sb); return p[63:32]; end
      2: begin p = 64'(sa * ub); return p[63:32]; end
      3: begin p = 64'(ua * ub); return p[63:32]; end
      4: begin if (b == 0) return '1; p = 64'(sa / sb); return p[31:0]; end
      5: begin if (b == 0) return '1; p = 64'(ua / ub); return p[31:0]; end
      6: begin if (b == 0) return a;  p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom % 6)
      0: return 32'h0;
      1: return MIN_INT;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if (rr_mode == 0) res_ready = ($urandom % 4) != 0;
    else              res_ready = (rr_mode == 2);
  end

  // Monitor: latency on first valid cycle, data and stability on handshake
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (res_valid[i]) begin
        if (!seen[i]) begin
          seen[i]  = 1'b1;
          first[i] = result[i];
          if (head[i] >= q.size()) begin
            chk($sformatf("dut%0d_unexpected_valid", i), 32'd1, 32'd0);
          end else begin
            chk($sformatf("dut%0d_latency", i), 32'(cyc - q[head[i]].acc + 1),
                (i == 1 && q[head[i]].early) ? 32'd1 : 32'd34);
          end
        end
        if (res_ready) begin
          if (head[i] < q.size()) begin
            chk($sformatf("dut%0d_result#%0d", i, head[i]), result[i], q[head[i]].val);
            chk($sformatf("dut%0d_stable#%0d", i, head[i]), result[i], first[i]);
            head[i]++;
          end
          seen[i] = 1'b0;
        end
      end
    end
  end

  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    while (!(req_ready[0] && req_ready[1])) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        chk("req_ready_timeout", 32'd0, 32'd1);
        return;
      end
    end
    funct3    = 3'(op);
    rs1       = a;
    rs2       = b;
    req_valid = 1'b1;
    e.val   = ref_md(op, a, b);
    e.acc   = cyc + 1;
    e.early = (op >= 4) && ((b == 0) || ((op == 4 || op == 6) && a == MIN_INT && b == 32'hFFFF_FFFF));
    q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    funct3    = 3'($urandom);
    rs1       = $urandom;
    rs2       = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!(req_ready[0] && req_ready[1] && head[0] == q.size() && head[1] == q.size())) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        chk("drain_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic discard_pending();
    head[0] = q.size();
    head[1] = q.size();
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_dut%0d_flags", tag, i),
          {29'h0, req_ready[i], res_valid[i], busy[i]}, 32'b100);
      chk($sformatf("%s_dut%0d_result", tag, i), result[i], 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold [2];
    int          n;
    head[0] = 0; head[1] = 0;
    seen[0] = 0; seen[1] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Directed vectors
    do_op(0, 32'd7, 32'hFFFF_FFFD);
    do_op(1, 32'h8000_0000, 32'h8000_0000);
    do_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(4, 32'hFFFF_FFF9, 32'd2);
    do_op(6, 32'hFFFF_FFF9, 32'd2);
    do_op(5, 32'd100, 32'd7);
    do_op(7, 32'd100, 32'd7);
    do_op(5, 32'd5, 32'd0);
    do_op(6, 32'd5, 32'd0);
    do_op(4, 32'hFFFF_FFF9, 32'd0);
    do_op(4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(6, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();

    // Backpressure: result held in DONE for 10 cycles
    rr_mode = 1;
    do_op(1, 32'h1234_5678, 32'h9ABC_DEF0);
    n = 0;
    @(negedge clk);
    while (!(res_valid[0] && res_valid[1]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", {31'h0, res_valid[0] & res_valid[1]}, 32'd1);
    hold[0] = result[0];
    hold[1] = result[1];
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("bp_dut%0d_flags", i), {30'h0, res_valid[i], req_ready[i]}, 32'b10);
        chk($sformatf("bp_dut%0d_hold", i), result[i], hold[i]);
      end
    end
    rr_mode = 2;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("bp_dut%0d_release", i), {30'h0, res_valid[i], req_ready[i]}, 32'b01);
    rr_mode = 0;
    drain();

    // Flush at CALC cycle 12
    do_op(5, 32'hDEAD_BEEF, 32'd13);
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    discard_pending();
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("flush_dut%0d_flags", i), {30'h0, req_ready[i], busy[i]}, 32'b10);
    do_op(6, 32'hDEAD_BEEF, 32'd13);
    drain();

    // Asynchronous reset mid-CALC
    do_op(0, 32'h0BAD_F00D, 32'h1357_9BDF);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    discard_pending();
    seen[0] = 0; seen[1] = 0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int unsigned k = 0; k < 60; k++)
      do_op(int'($urandom % 8), pick_operand(), pick_operand());
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide execute unit. It is the parametrised successor to the combinational ALU control/ALU path.
- Decodes M-extension funct3 and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over XLEN cycles with a shift-add / restoring-divide datapath.
- Sits in EX beside the ALU. The pipeline stalls on busy_o.
- Uses a valid/ready handshake on both the request and result sides, plus a flush input.

Parameters:
- XLEN, 32, operand/result width (≥8, even).
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow skip iteration and complete in 1 cycle.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  abort in-flight op and drop any held result.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request (state IDLE).
- funct3_i  in  3  M-op select, encoded as md_op_e.
- rs1_i  in  XLEN  operand A.
- rs2_i  in  XLEN  operand B.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  result.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, req_ready_o=1, res_valid_o=0, result_o=0, busy_o=0, counter=0.
- FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - Accept happens on req_valid_i & req_ready_o.
  - Latch the op and compute operand signedness: MUL/MULH/DIV/REM signed both; MULHSU A signed, B unsigned; others unsigned.
  - Store absolute values and the result sign. Result sign for quotient is sA^sB; for remainder it is sA.
  - Counter=XLEN. Next state is CALC.
  - If EARLY_OUT=1 and the op is div/rem with rs2=0: next state is DONE, with result = all-ones (DIV/DIVU) or rs1 (REM/REMU).
  - If EARLY_OUT=1 and the op is DIV/REM with rs1=MIN_INT and rs2=-1: next state is DONE, with result = MIN_INT (DIV) or 0 (REM).
  - If EARLY_OUT=0, these special cases fall out of the iteration naturally after sign fix. The results must be identical to the early-out values.
- CALC:
  - One iteration per cycle; counter decrements.
  - Mul: 2*XLEN-bit accumulator, shift-add on the LSB of the multiplier.
  - Div: restoring; the remainder shifts left, subtracts the divisor, and the quotient bit is set if the result is non-negative.
  - When counter reaches 1 on this edge, next state is FIX.
- FIX:
  - Apply two's-complement negation if the result sign is set.
  - Select the output: MUL = low XLEN; MULH* = high XLEN; DIV* = quotient; REM* = remainder.
  - Register into result_o. Next state is DONE.
- DONE:
  - res_valid_o=1. result_o is stable while res_valid_o & !res_ready_i (backpressure holds indefinitely).
  - On res_ready_i the state goes to IDLE.
  - A new request is not accepted in the same cycle (req_ready_o=0 in DONE).
- Latency: normal op gives res_valid_o high after accept edge + XLEN + 1 edges (34 for XLEN=32). Early-out gives it after accept edge + 1 edge.
- Throughput: one op per XLEN+3 cycles minimum.
- flush_i:
  - Synchronous. Highest priority after reset.
  - Next state is IDLE, res_valid_o=0. An accept in the same cycle is ignored.
  - result_o keeps its last value (not meaningful).
- Ignored inputs: funct3_i, rs1_i and rs2_i are ignored outside the accept cycle.
- Width rules: MULHSU treats rs2 as unsigned. The sign-fix negation covers all 2*XLEN bits before the upper half is selected.

Decomposition:
- Shared package mycpu_pkg gains:
  - md_op_e (3-bit enum, values = RV32M funct3: MUL=000 … REMU=111).
  - mdu_state_e (IDLE, CALC, FIX, DONE).
  - M-extension constant FUNCT7_MULDIV=7'b0000001 for use by the decoder that selects this unit.
- Single module. The FSM and datapath are small enough that no sub-module is warranted.

Test Plan:
- MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB; res_valid_o exactly 34 edges after accept.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide-by-zero and overflow:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
  - With EARLY_OUT=1, valid 1 edge after accept. With EARLY_OUT=0, same values at 34 edges.
- Backpressure: hold res_ready_i=0 for 10 cycles in DONE -> res_valid_o and result_o stable, req_ready_o=0; release -> IDLE the next edge.
- Flush and reset:
  - Assert flush_i at CALC cycle 12 -> IDLE next edge, no res_valid_o pulse; the next request completes correctly.
  - Assert rst_i asynchronously mid-CALC -> outputs go to their reset values immediately, without waiting for a clock edge.
